recirculation_mux_arbiter: RTL
==============================

# recirculation_mux_arbiter

Source-domain scheduler that shares one recirculation-mux CDC channel among several requesters in the A clock domain. It round-robin arbitrates between requesters and captures the winner's word into a stable hold register. It then issues the single-cycle launch pulse to the toggle synchronizer and holds the data until the destination's synchronized acknowledge returns, or until a timeout expires. Its outputs drive the recirculation mux's `i_pulse_A`/`i_data_A` inputs. The B→A ack path arrives already synchronized into `i_clk`.

## Interface
- `g_requesters`, 4 — number of requesters; legal range ≥2.
- `g_width`, 8 — data word width.
- `g_timeout`, 15 — maximum cycles spent in WAIT before abort; 0 disables the timeout.

- `i_clk`  in  1  — A-domain clock; all logic is on its rising edge.
- `i_rst_n`  in  1  — one clock; reset is asynchronous and active-low.
- `i_valid`  in  g_requesters  — per-requester request.
- `i_data`  in  g_requesters*g_width  — packed words; requester k occupies `[k*g_width +: g_width]`.
- `o_ready`  out  g_requesters  — combinational accept; at most one bit high.
- `i_ack`  in  1  — single-cycle pulse: destination has sampled the data (already synchronized to `i_clk`).
- `o_pulse_A`  out  1  — single-cycle launch pulse to the synchronizer.
- `o_data_A`  out  g_width  — held data word to the mux.
- `o_grant`  out  g_requesters  — registered one-hot owner of the in-flight transfer; 0 when idle.
- `o_busy`  out  1  — high while in WAIT.
- `o_timeout`  out  1  — single-cycle pulse on timeout abort.
- `o_timeout_cnt`  out  8  — saturating count of timeout aborts.

## Operation
- FSM states:
  - IDLE: no transfer in flight.
  - WAIT: transfer in flight, waiting for ack or timeout.
- Round-robin pointer `ptr` (0..g_requesters-1):
  - Winner is the first k with `i_valid[k]=1`, searching from `ptr` upward and wrapping.
  - On each accept, `ptr` becomes winner+1 mod g_requesters.
- IDLE:
  - `o_ready` equals the one-hot winner; it is 0 when no valid request is present.
  - A handshake completes when `i_valid[k] & o_ready[k]`.
  - On handshake:
    - `o_data_A` ← word k.
    - `o_grant` ← one-hot k.
    - `o_pulse_A` ← 1 for the next cycle only.
    - Timeout counter ← 0.
    - State → WAIT.
- WAIT:
  - `o_ready` = 0.
  - `o_data_A` and `o_grant` are held.
  - Counter increments every cycle.
  - If `i_ack`=1: state → IDLE and `o_grant` ← 0. `o_data_A` keeps its last value, so the mux output stays stable.
  - Else, if g_timeout≠0 and the counter equals g_timeout−1:
    - `o_timeout` pulses.
    - `o_timeout_cnt` increments, saturating at 255.
    - State → IDLE and `o_grant` ← 0.
- `i_ack` received in IDLE is ignored, with no state change.
- Requesters may deassert `i_valid` at any time before the handshake; no request is latched before its handshake.
- Counter width is clog2(g_timeout+1), with a minimum of 1.

## Timing
- Reset (asynchronous assertion, synchronous release):
  - State = IDLE, `ptr` = 0, counter = 0.
  - `o_data_A` = 0, `o_grant` = 0, `o_pulse_A` = 0, `o_busy` = 0, `o_timeout` = 0, `o_timeout_cnt` = 0.
  - `o_ready` = 0 while `i_rst_n` = 0.
- Reset in WAIT aborts the transfer with no `o_timeout` pulse.
- Handshake at edge t gives: `o_pulse_A`, `o_busy`, `o_grant` and the new `o_data_A` all valid from t through t+1. `o_pulse_A` is low again after edge t+1.
- `i_ack` sampled at edge u returns the block to IDLE. The earliest next handshake is edge u+1, so there are at least 2 cycles between successive `o_pulse_A` pulses.
- `i_ack` coincident with the launch-pulse cycle is accepted normally.
- `i_ack` in the same cycle as timeout expiry: ack wins, with no `o_timeout` and no count change.
- With g_timeout = N: abort happens N cycles after the handshake edge, i.e. `o_busy` is high for exactly N cycles.
- Throughput with immediate ack: one transfer every 2 cycles.

## Test plan
- Reset, then `i_valid` = 4'b0100 with word2 = 8'hA5, then `i_ack` 3 cycles after the pulse:
  - `o_ready` = 4'b0100 and a single `o_pulse_A`.
  - `o_data_A` = A5 held until after the ack; `o_grant` = 4'b0100.
  - `o_busy` high for 3 cycles.
- All four `i_valid` held high, with ack 1 cycle after each pulse: grants in the order 0, 1, 2, 3, 0; data matches each requester's word.
- No ack with g_timeout = 15:
  - `o_timeout` pulses once, 15 cycles after the handshake.
  - `o_timeout_cnt` = 1; `o_grant` → 0; `o_data_A` unchanged.
- `i_ack` on exactly the expiry cycle: no `o_timeout`, and `o_timeout_cnt` stays 0.
- `i_rst_n` pulled low asynchronously mid-WAIT:
  - All outputs clear immediately, with `o_data_A` = 0.
  - After release, requester 0 wins first.
- Stray `i_ack` pulses in IDLE, plus 300 forced timeouts:
  - The stray acks cause no state change.
  - `o_timeout_cnt` saturates at 255.

Source files
------------

// File: rtl/recirculation_mux_arbiter.sv
// Source-domain scheduler for a shared recirculation-mux CDC channel: round-robin
// picks a requester, holds its word, launches the sync pulse and waits for ack or timeout.
module recirculation_mux_arbiter #(
    parameter int g_requesters = 4,
    parameter int g_width      = 8,
    parameter int g_timeout    = 15
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [g_requesters-1:0]           i_valid,
    input  logic [g_requesters*g_width-1:0]   i_data,
    output logic [g_requesters-1:0]           o_ready,
    input  logic                              i_ack,
    output logic                              o_pulse_A,
    output logic [g_width-1:0]                o_data_A,
    output logic [g_requesters-1:0]           o_grant,
    output logic                              o_busy,
    output logic                              o_timeout,
    output logic [7:0]                        o_timeout_cnt
);

    localparam int PW = $clog2(g_requesters);
    localparam int CW = (g_timeout < 1) ? 1 : $clog2(g_timeout + 1);
    localparam logic [CW-1:0] CNT_LAST = (g_timeout < 1) ? '0 : CW'(g_timeout - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(g_requesters - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           ptr_q, ptr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [g_width-1:0]      data_q, data_d;
    logic [g_requesters-1:0] grant_q, grant_d;
    logic                    pulse_q, pulse_d;
    logic                    timeout_q, timeout_d;
    logic [7:0]              to_cnt_q, to_cnt_d;

    logic                    win_found;
    logic [PW-1:0]           win_idx;
    logic [g_requesters-1:0] win_onehot;
    logic [g_width-1:0]      win_data;
    logic                    handshake;
    int                      k;

    // Search upward from the round-robin pointer, wrapping, for the first valid requester.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        win_found = 1'b0;
        win_idx   = '0;
        k         = 0;
        for (int i = 0; i < g_requesters; i++) begin
            k = (int'(ptr_q) + i) % g_requesters;
            if (!win_found && i_valid[PW'(k)]) begin
                win_found = 1'b1;
                win_idx   = PW'(k);
            end
        end
    end

    always_comb begin
        win_onehot = '0;
        win_data   = '0;
        if (win_found) win_onehot[win_idx] = 1'b1;
        for (int j = 0; j < g_requesters; j++) begin
            if (win_onehot[j]) win_data = i_data[j*g_width +: g_width];
        end
    end

    assign o_ready   = (state_q == S_IDLE && i_rst_n) ? win_onehot : '0;
    assign handshake = |(i_valid & o_ready);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        grant_d   = grant_q;
        pulse_d   = 1'b0;
        timeout_d = 1'b0;
        to_cnt_d  = to_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    data_d  = win_data;
                    grant_d = win_onehot;
                    pulse_d = 1'b1;
                    cnt_d   = '0;
                    ptr_d   = (win_idx == PTR_LAST) ? '0 : win_idx + 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // Ack has priority over a coincident timeout expiry.
                if (i_ack) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                end else if (g_timeout != 0 && cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    if (to_cnt_q != 8'hFF) to_cnt_d = to_cnt_q + 8'd1;
                    state_d = S_IDLE;
                    grant_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            grant_q   <= '0;
            pulse_q   <= 1'b0;
            timeout_q <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            grant_q   <= grant_d;
            pulse_q   <= pulse_d;
            timeout_q <= timeout_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    assign o_pulse_A     = pulse_q;
    assign o_data_A      = data_q;
    assign o_grant       = grant_q;
    assign o_busy        = (state_q == S_WAIT);
    assign o_timeout     = timeout_q;
    assign o_timeout_cnt = to_cnt_q;

endmodule
